// File: rtl/time_scale_selector_if.sv
// ---------------------------------------------------------------------------
// time_scale_selector_if
//   Front-panel bundle between the panel/UI side and time_scale_selector.
//   btn_up, btn_down : raw asynchronous push-buttons, 1 = pressed
//   scale_reset      : one-cycle pulse, restores the reset time-base index
//   scale_out        : current 5-bit time-base index
//   scale_changed    : one-cycle pulse when scale_out takes a new value
//   at_min, at_max   : index sits at the low / high end of the table
//   master modport : panel/UI side (drives buttons, reads status)
//   slave modport  : selector side
// ---------------------------------------------------------------------------
interface time_scale_selector_if;
    logic       btn_up;
    logic       btn_down;
    logic       scale_reset;
    logic [4:0] scale_out;
    logic       scale_changed;
    logic       at_min;
    logic       at_max;

    modport master (
        output btn_up, btn_down, scale_reset,
        input  scale_out, scale_changed, at_min, at_max
    );

    modport slave (
        input  btn_up, btn_down, scale_reset,
        output scale_out, scale_changed, at_min, at_max
    );
endinterface

// File: rtl/time_scale_selector.sv
// ---------------------------------------------------------------------------
// time_scale_selector
//   Produces the time-base index for the time-scale lookup table from the
//   up/down front-panel buttons. Buttons are synchronised, debounced, turned
//   into single steps per press with hold-to-repeat, and the index saturates
//   at both ends of the table.
//
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : time_scale_selector_if.slave
//            inputs  btn_up, btn_down, scale_reset
//            outputs scale_out, scale_changed, at_min, at_max (all registered)
// ---------------------------------------------------------------------------
module time_scale_selector #(
    parameter int NUM_SCALES          = 20,
    parameter int RESET_SCALE         = 14,
    parameter int DEBOUNCE_CYCLES     = 1000000,
    parameter int REPEAT_DELAY_CYCLES = 50000000,
    parameter int REPEAT_RATE_CYCLES  = 10000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    time_scale_selector_if.slave  bus
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;

    localparam logic [4:0]       MAX_IDX   = 5'(NUM_SCALES - 1);
    localparam logic [4:0]       RST_IDX   = 5'(RESET_SCALE);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DLY_LAST  = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE_CYCLES - 1);

    // Bit 0 = up button, bit 1 = down button.
    logic [1:0] btn_raw;
    logic [1:0] db_lvl;
    logic [1:0] db_rise;

    assign btn_raw = {bus.btn_down, bus.btn_up};

    // -----------------------------------------------------------------------
    // Per-button synchroniser + debouncer + rising-edge detector
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic            sync1_q;
            logic            sync2_q;
            logic            db_q;
            logic            db_prev_q;
            logic [DB_W-1:0] db_cnt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q   <= 1'b0;
                    sync2_q   <= 1'b0;
                    db_q      <= 1'b0;
                    db_prev_q <= 1'b0;
                    db_cnt_q  <= '0;
                end else begin
                    sync1_q   <= btn_raw[gi];
                    sync2_q   <= sync1_q;
                    db_prev_q <= db_q;
                    // Any cycle where the synchronised level agrees with the
                    // accepted level restarts the stability count.
                    if (sync2_q == db_q) begin
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        db_q     <= sync2_q;
                        db_cnt_q <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
            end

            assign db_lvl[gi]  = db_q;
            // Seen in the cycle after the debounced level rises.
            assign db_rise[gi] = db_q & ~db_prev_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Press / hold-to-repeat FSM and index register
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD_UP = 2'd1,
        HOLD_DN = 2'd2,
        BOTH    = 2'd3
    } state_t;

    state_t           state_q;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic             rpt_first_q;   // still waiting for the initial long delay
    logic [4:0]       scale_q;
    logic             changed_q;
    logic             at_min_q;
    logic             at_max_q;

    logic             in_hold;
    logic             rpt_tick;
    logic             step_up;
    logic             step_dn;
    logic [4:0]       scale_d;

    assign in_hold  = (state_q == HOLD_UP) || (state_q == HOLD_DN);
    assign rpt_tick = in_hold &&
                      (rpt_cnt_q == (rpt_first_q ? DLY_LAST : RATE_LAST));

    // A repeat tick only steps while the own button is still held and the
    // opposite one is not arriving in the same cycle (that cycle goes to BOTH).
    assign step_up = ((state_q == IDLE)    && db_rise[0] && !db_lvl[1]) ||
                     ((state_q == HOLD_UP) && db_lvl[0]  && !db_rise[1] && rpt_tick);
    assign step_dn = ((state_q == IDLE)    && db_rise[1] && !db_lvl[0]) ||
                     ((state_q == HOLD_DN) && db_lvl[1]  && !db_rise[0] && rpt_tick);

    // scale_reset wins over any step; steps at the table ends hold the value.
    always_comb begin
        scale_d = scale_q;
        if (bus.scale_reset) begin
            scale_d = RST_IDX;
        end else if (step_up && (scale_q < MAX_IDX)) begin
            scale_d = scale_q + 5'd1;
        end else if (step_dn && (scale_q != 5'd0)) begin
            scale_d = scale_q - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
            scale_q     <= RST_IDX;
            changed_q   <= 1'b0;
            at_min_q    <= (RST_IDX == 5'd0);
            at_max_q    <= (RST_IDX == MAX_IDX);
        end else begin
            scale_q   <= scale_d;
            changed_q <= (scale_d != scale_q);
            at_min_q  <= (scale_d == 5'd0);
            at_max_q  <= (scale_d == MAX_IDX);

            case (state_q)
                IDLE: begin
                    rpt_cnt_q   <= '0;
                    rpt_first_q <= 1'b1;
                    if (db_rise[0] && !db_lvl[1]) begin
                        state_q <= HOLD_UP;
                    end else if (db_rise[1] && !db_lvl[0]) begin
                        state_q <= HOLD_DN;
                    end else if (db_rise[0] || db_rise[1]) begin
                        // Simultaneous press (or a press with the other held).
                        state_q <= BOTH;
                    end
                end
                HOLD_UP, HOLD_DN: begin
                    if ((state_q == HOLD_UP) ? db_rise[1] : db_rise[0]) begin
                        state_q <= BOTH;
                    end else if ((state_q == HOLD_UP) ? !db_lvl[0] : !db_lvl[1]) begin
                        state_q <= IDLE;
                    end else if (rpt_tick) begin
                        rpt_cnt_q   <= '0;
                        rpt_first_q <= 1'b0;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + 1'b1;
                    end
                end
                BOTH: begin
                    // Full release required before any new press is accepted.
                    if (!db_lvl[0] && !db_lvl[1]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // scale_reset leaves the state path alone but makes a held button
            // wait the full initial delay again before repeating.
            if (bus.scale_reset) begin
                rpt_cnt_q   <= '0;
                rpt_first_q <= 1'b1;
            end
        end
    end

    assign bus.scale_out     = scale_q;
    assign bus.scale_changed = changed_q;
    assign bus.at_min        = at_min_q;
    assign bus.at_max        = at_max_q;

endmodule

// File: tb/tb_time_scale_selector.sv
// ---------------------------------------------------------------------------
// tb_time_scale_selector
//   Bench for time_scale_selector with short debounce/repeat timings.
//   Expected index changes (cycle + value) are queued when a button is driven
//   and matched against every scale_changed pulse the DUT produces.
// ---------------------------------------------------------------------------
module tb_time_scale_selector;

    localparam int DEB  = 4;
    localparam int DLY  = 20;
    localparam int RATE = 5;
    localparam int NS   = 20;
    localparam int RS   = 14;
    localparam int LAT  = 2 + DEB + 1;   // raw press to index change

    localparam logic [4:0] MAX_IDX = 5'(NS - 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    time_scale_selector_if bus();

    time_scale_selector #(
        .NUM_SCALES         (NS),
        .RESET_SCALE        (RS),
        .DEBOUNCE_CYCLES    (DEB),
        .REPEAT_DELAY_CYCLES(DLY),
        .REPEAT_RATE_CYCLES (RATE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    typedef struct {
        bit up;
        bit dn;
        bit bounce;     // toggle btn_down every cycle instead of a clean press
        int hold;
        int exp_idx;
        bit exp_step;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[7];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [4:0] prev_scale = 5'(RS);

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Runs at the falling edge, away from the DUT's active edge.
    task automatic monitor();
        exp_t e;
        if (!rst_n) begin
            prev_scale = bus.scale_out;
            return;
        end
        if (bus.scale_changed) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_pulse", int'(bus.scale_out), int'(prev_scale));
            end else begin
                e = exp_q.pop_front();
                chk(e.cyc == cyc, "pulse_cycle", cyc, e.cyc);
                chk(int'(bus.scale_out) == e.val, "pulse_value", int'(bus.scale_out), e.val);
            end
        end else begin
            chk(bus.scale_out == prev_scale, "silent_change", int'(bus.scale_out), int'(prev_scale));
        end
        chk(bus.at_min == (bus.scale_out == 5'd0), "at_min_decode",
            int'(bus.at_min), int'(bus.scale_out == 5'd0));
        chk(bus.at_max == (bus.scale_out == MAX_IDX), "at_max_decode",
            int'(bus.at_max), int'(bus.scale_out == MAX_IDX));
        prev_scale = bus.scale_out;
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic push(input int c, input int v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic drained(input string name);
        chk(exp_q.size() == 0, name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic press(input bit up, input bit dn, input int hold);
        bus.btn_up   = up;
        bus.btn_down = dn;
        run(hold);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
    endtask

    initial begin
        int start;

        // up, dn, bounce, hold, exp_idx, exp_step  (starting from index 14)
        vecs[0] = '{1'b1, 1'b0, 1'b0, 10, 15, 1'b1};   // clean up press
        vecs[1] = '{1'b0, 1'b1, 1'b0, 10, 14, 1'b1};   // clean down press
        vecs[2] = '{1'b0, 1'b1, 1'b1, 30, 14, 1'b0};   // bouncing down: rejected
        vecs[3] = '{1'b1, 1'b0, 1'b0,  3, 14, 1'b0};   // one cycle too short
        vecs[4] = '{1'b1, 1'b0, 1'b0,  4, 15, 1'b1};   // shortest accepted press
        vecs[5] = '{1'b1, 1'b1, 1'b0, 10, 15, 1'b0};   // simultaneous: no step
        vecs[6] = '{1'b0, 1'b1, 1'b0, 10, 14, 1'b1};

        bus.btn_up      = 1'b0;
        bus.btn_down    = 1'b0;
        bus.scale_reset = 1'b0;

        // ---- reset state ----
        #2 rst_n = 1'b0;
        run(3);
        chk(bus.scale_out == 5'(RS), "reset_scale", int'(bus.scale_out), RS);
        chk(bus.scale_changed == 1'b0, "reset_changed", int'(bus.scale_changed), 0);
        chk(bus.at_min == 1'b0, "reset_at_min", int'(bus.at_min), 0);
        chk(bus.at_max == 1'b0, "reset_at_max", int'(bus.at_max), 0);
        rst_n = 1'b1;
        run(3);

        // ---- table-driven single presses ----
        for (int v = 0; v < 7; v++) begin
            start = cyc;
            if (vecs[v].exp_step) push(start + LAT, vecs[v].exp_idx);
            if (vecs[v].bounce) begin
                for (int i = 0; i < vecs[v].hold; i++) begin
                    bus.btn_down = ~bus.btn_down;
                    cycle();
                end
                bus.btn_down = 1'b0;
            end else begin
                press(vecs[v].up, vecs[v].dn, vecs[v].hold);
            end
            run(20);
            chk(int'(bus.scale_out) == vecs[v].exp_idx, "vec_index",
                int'(bus.scale_out), vecs[v].exp_idx);
            drained("vec_pending");
            $display("vec %0d: up=%0b dn=%0b bounce=%0b hold=%0d -> index %0d",
                     v, vecs[v].up, vecs[v].dn, vecs[v].bounce, vecs[v].hold, bus.scale_out);
        end

        // ---- hold up 60 cycles from 14: press step + repeats, saturate at 19 ----
        start = cyc;
        push(start + LAT, 15);
        for (int k = 0; k < 4; k++) push(start + LAT + DLY + k * RATE, 16 + k);
        press(1'b1, 1'b0, 60);
        run(20);
        chk(bus.scale_out == MAX_IDX, "hold_up_sat", int'(bus.scale_out), NS - 1);
        chk(bus.at_max == 1'b1, "hold_up_at_max", int'(bus.at_max), 1);
        drained("hold_up_pending");
        $display("hold up 60: index %0d at_max=%0b", bus.scale_out, bus.at_max);

        // ---- scale_reset back to 14, then hold down to 0 with repeats ----
        start = cyc;
        push(start + 1, RS);
        bus.scale_reset = 1'b1;
        cycle();
        bus.scale_reset = 1'b0;
        run(3);
        start = cyc;
        push(start + LAT, RS - 1);
        for (int k = 1; k <= RS - 1; k++) push(start + LAT + DLY + (k - 1) * RATE, RS - 1 - k);
        press(1'b0, 1'b1, 100);
        run(20);
        chk(bus.scale_out == 5'd0, "hold_dn_sat", int'(bus.scale_out), 0);
        drained("hold_dn_pending");
        $display("hold down 100: index %0d at_min=%0b", bus.scale_out, bus.at_min);

        // ---- press down at 0: no change, no pulse ----
        press(1'b0, 1'b1, 10);
        run(20);
        chk(bus.scale_out == 5'd0, "min_hold", int'(bus.scale_out), 0);
        chk(bus.at_min == 1'b1, "min_at_min", int'(bus.at_min), 1);
        drained("min_pending");
        $display("down at min: index %0d", bus.scale_out);

        // ---- up held, then down pressed: no more steps until full release ----
        start = cyc;
        push(start + LAT, 1);
        bus.btn_up = 1'b1;
        run(12);
        bus.btn_down = 1'b1;
        run(28);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        run(20);
        chk(bus.scale_out == 5'd1, "both_index", int'(bus.scale_out), 1);
        drained("both_pending");
        start = cyc;
        push(start + LAT, 0);
        press(1'b0, 1'b1, 10);
        run(20);
        chk(bus.scale_out == 5'd0, "after_both_dn", int'(bus.scale_out), 0);
        drained("after_both_pending");
        $display("both held then lone down: index %0d", bus.scale_out);

        // ---- climb to 3 ----
        for (int v = 1; v <= 3; v++) begin
            start = cyc;
            push(start + LAT, v);
            press(1'b1, 1'b0, 10);
            run(20);
        end
        chk(bus.scale_out == 5'd3, "climb_index", int'(bus.scale_out), 3);
        drained("climb_pending");

        // ---- scale_reset in the same cycle as a step up from 3 ----
        start = cyc;
        push(start + LAT, RS);
        bus.btn_up = 1'b1;
        run(LAT - 1);
        bus.scale_reset = 1'b1;
        cycle();
        bus.scale_reset = 1'b0;
        run(3);
        bus.btn_up = 1'b0;
        run(20);
        chk(bus.scale_out == 5'(RS), "reset_vs_step", int'(bus.scale_out), RS);
        drained("reset_vs_step_pending");
        $display("scale_reset with step from 3: index %0d", bus.scale_out);

        // ---- rst_n asserted while up is held: async return, fresh debounce ----
        start = cyc;
        push(start + LAT, RS + 1);
        bus.btn_up = 1'b1;
        run(15);
        rst_n = 1'b0;
        #1;
        chk(bus.scale_out == 5'(RS), "async_reset_scale", int'(bus.scale_out), RS);
        chk(bus.scale_changed == 1'b0, "async_reset_changed", int'(bus.scale_changed), 0);
        drained("pre_reset_pending");
        run(4);
        rst_n = 1'b1;
        start = cyc;
        push(start + LAT, RS + 1);
        run(10);
        bus.btn_up = 1'b0;
        run(20);
        chk(bus.scale_out == 5'(RS + 1), "post_reset_press", int'(bus.scale_out), RS + 1);
        drained("post_reset_pending");
        $display("rst_n during hold: index %0d after fresh debounce", bus.scale_out);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_scale_selector.md
Name: time_scale_selector

Overview:
Front-panel controller that produces the 5-bit time-base index (scale_out) consumed by the time-scale lookup table.
- Synchronises and debounces raw up/down push-buttons.
- Steps the index one position per press, with hold-to-repeat.
- Saturates at the table ends and reports limit and change status to the UI/OSD logic.

Parameters:
NUM_SCALES, 20, number of valid indices (0..NUM_SCALES-1); indices at or above NUM_SCALES are never produced
RESET_SCALE, 14, index loaded at reset and on scale_reset (1 ms/div)
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles required to accept a level change (10 ms at 100 MHz)
REPEAT_DELAY_CYCLES, 50000000, hold time before the first auto-repeat step
REPEAT_RATE_CYCLES, 10000000, interval between subsequent auto-repeat steps

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
btn_up  input  1  raw asynchronous button, 1 = pressed, increases index (slower sweep)
btn_down  input  1  raw asynchronous button, 1 = pressed, decreases index
scale_reset  input  1  synchronous one-cycle pulse, restores RESET_SCALE
scale_out  output  5  current time-base index
scale_changed  output  1  one-cycle pulse in the cycle scale_out takes a new value
at_min  output  1  high while scale_out == 0
at_max  output  1  high while scale_out == NUM_SCALES-1

Behaviour:
Reset (rst_n low, asynchronous):
- scale_out = RESET_SCALE; scale_changed = 0.
- at_min/at_max reflect RESET_SCALE (0/0 at default).
- Synchronisers, debounced levels and counters cleared; FSM = IDLE.
Synchronisation:
- Each button passes through a 2-FF synchroniser (s_up, s_dn).
Debounce, per button:
- Counter increments each cycle s != db and clears whenever s == db.
- When the counter reaches DEBOUNCE_CYCLES-1 with s != db, db <= s and the counter clears.
- Counter width = clog2(DEBOUNCE_CYCLES)+1.
Step requests:
- step_up / step_dn assert on the cycle after the debounced rising edge, or on a repeat tick.
- Applied to scale_out on the same edge they assert.
- Total latency, raw stable press to scale_out change: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Release generates no step.
Arithmetic:
- Up: scale_out < NUM_SCALES-1 -> +1; else hold with no scale_changed pulse.
- Down: scale_out > 0 -> -1; else hold with no scale_changed pulse.
- No wrap-around in either direction.
FSM states: IDLE, HOLD_UP, HOLD_DN, BOTH.
- IDLE: db_up rise with db_dn low -> step up, HOLD_UP, repeat counter = 0.
- IDLE: db_dn rise with db_up low -> step down, HOLD_DN.
- IDLE: both rise in the same cycle -> BOTH, no step.
- HOLD_UP / HOLD_DN: repeat counter increments each cycle.
  - First tick when it reaches REPEAT_DELAY_CYCLES-1, then every REPEAT_RATE_CYCLES.
  - Each tick -> one step in that direction.
  - Repeats continue at the limit but produce no change and no pulse.
- HOLD_* and the opposite button's db rises -> BOTH, no step.
- HOLD_* and the own db falls -> IDLE.
- BOTH: no steps; -> IDLE only when both db are low. Re-pressing requires full release.
scale_reset:
- Highest priority: in that cycle scale_out <= RESET_SCALE.
- Any concurrent step is discarded.
- FSM state unchanged; the repeat counter restarts its delay.
- scale_changed pulses only if the value differs.
Outputs:
- All outputs registered.
- at_min/at_max are registered decodes updated on the same edge as scale_out.
- scale_changed is high for exactly one cycle per actual value change.
Reset mid-operation:
- Immediate return to the reset state; a held button must be debounced again after rst_n rises.
- Such a button counts as a new press (db starts at 0).

Test Plan:
Simulation parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=5.
- Reset -> scale_out=14, at_min=0, at_max=0, scale_changed=0; one clean btn_up press of 10 cycles -> scale_out=15 exactly 7 cycles after press, single 1-cycle scale_changed pulse.
- btn_down toggling every cycle for 30 cycles, then low -> no step, scale_out stays 14.
- Hold btn_up 60 cycles from index 14 -> steps at press and at delay ticks 20, 25, 30, ... -> saturates at 19, at_max=1; total scale_changed pulses = 5.
- From 0, press btn_down -> scale_out stays 0, at_min=1, no scale_changed pulse.
- Hold btn_up, then press btn_down while up is still held -> no further steps until both released; next lone btn_down press -> index -1.
- scale_reset pulse at the same cycle as a step_up, from index 3 -> scale_out=14, one pulse; rst_n low while holding btn_up -> scale_out=14 asynchronously, new step only after a fresh debounce.
